// File: rtl/icache_pkg.sv
// Shared types and default geometry for the set-associative instruction cache.
// The default geometry below is the reference configuration; derived widths follow from it.
package icache_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_e;

    localparam int LINE_LENGTH_DEF = 4;
    localparam int NSETS_DEF       = 4;
    localparam int WAYS_DEF        = 2;
    localparam int RV_DEF          = 16;
    localparam int PA_DEF          = 22;
    localparam int DW_DEF          = 4;

    localparam int BEATS      = LINE_LENGTH_DEF * 8 / DW_DEF;
    localparam int OFF_W      = $clog2(LINE_LENGTH_DEF);
    localparam int IDX_W      = $clog2(NSETS_DEF);
    localparam int TAG_W      = PA_DEF - OFF_W - IDX_W;
    localparam int WORD_SEL_W = OFF_W - $clog2(RV_DEF / 8);

endpackage

// File: rtl/icache_sa_if.sv
// Fetch / fill-memory bus of the instruction cache.
// The flush signal exists only when ICACHE_FLUSH_EN is defined.
interface icache_sa_if #(
    parameter int PA   = 22,
    parameter int DW   = 4,
    parameter int RV   = 16,
    parameter int LA_W = 20
);
    logic [PA-1:0]   paddr;
    logic            req;
    logic            fault;
    logic [DW-1:0]   dread;
    logic            wstrobe_d;
    logic            hit;
    logic            pull;
    logic [LA_W-1:0] tag;
    logic [RV-1:0]   rdata;
    logic            err;
`ifdef ICACHE_FLUSH_EN
    logic            flush;

    modport master (output paddr, req, fault, dread, wstrobe_d, flush,
                    input  hit, pull, tag, rdata, err);
    modport slave  (input  paddr, req, fault, dread, wstrobe_d, flush,
                    output hit, pull, tag, rdata, err);
`else
    modport master (output paddr, req, fault, dread, wstrobe_d,
                    input  hit, pull, tag, rdata, err);
    modport slave  (input  paddr, req, fault, dread, wstrobe_d,
                    output hit, pull, tag, rdata, err);
`endif
endinterface

// File: rtl/icache_way.sv
// One way of the cache: valid bits, tag array and line data array.
// Beat-granular write port, tag commit, single-line invalidate, whole-way flush,
// and a combinational lookup port.
module icache_way #(
    parameter int NSETS     = 4,
    parameter int IDX_BITS  = 2,
    parameter int TAG_BITS  = 18,
    parameter int LINE_BITS = 32,
    parameter int DW        = 4,
    parameter int BEAT_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_i,
    input  logic                 inval_i,
    input  logic                 wr_en_i,
    input  logic                 commit_i,
    input  logic [IDX_BITS-1:0]  wr_idx_i,
    input  logic [TAG_BITS-1:0]  wr_tag_i,
    input  logic [BEAT_BITS-1:0] wr_beat_i,
    input  logic [DW-1:0]        wr_data_i,
    input  logic [IDX_BITS-1:0]  rd_idx_i,
    input  logic [TAG_BITS-1:0]  rd_tag_i,
    output logic                 valid_o,
    output logic                 hit_o,
    output logic [LINE_BITS-1:0] line_o
);
    logic [NSETS-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [NSETS];
    logic [LINE_BITS-1:0] data_q [NSETS];

    // Valid bits: cleared by reset/flush/abort, set only when a whole line has landed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (flush_i) begin
            valid_q <= '0;
        end else if (inval_i) begin
            valid_q[wr_idx_i] <= 1'b0;
        end else if (commit_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    // Tag and data storage written beat by beat during a fill.
    // NOTE: storage arrays have no reset; the valid bits alone decide whether contents are visible.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][int'(wr_beat_i) * DW +: DW] <= wr_data_i;
        end
        if (commit_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
    end

    assign valid_o = valid_q[rd_idx_i];
    assign hit_o   = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign line_o  = data_q[rd_idx_i];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache (1 or 2 ways) with LRU replacement,
// combinational hit/data lookup and a registered line-fill FSM.
// Optional feature: define ICACHE_FLUSH_EN to add the flush input.
module icache_sa
    import icache_pkg::*;
#(
    parameter int LINE_LENGTH = LINE_LENGTH_DEF,
    parameter int NSETS       = NSETS_DEF,
    parameter int WAYS        = WAYS_DEF,
    parameter int RV          = RV_DEF,
    parameter int PA          = PA_DEF,
    parameter int DW          = DW_DEF
) (
    input logic        clk,
    input logic        reset_n,
    icache_sa_if.slave bus
);
    localparam int OFF_BITS  = $clog2(LINE_LENGTH);
    localparam int IDX_BITS  = $clog2(NSETS);
    localparam int LA_BITS   = PA - OFF_BITS;
    localparam int TAG_BITS  = LA_BITS - IDX_BITS;
    localparam int LINE_BITS = LINE_LENGTH * 8;
    localparam int NBEATS    = LINE_BITS / DW;
    localparam int BEAT_BITS = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int RVB_BITS  = $clog2(RV / 8);

    state_e               state_q, state_d;
    logic [LA_BITS-1:0]   tag_q;
    logic [BEAT_BITS-1:0] beat_q;
    logic                 victim_q, victim_d;
    logic                 err_q;

    logic                 flush;
    logic                 hit_int, hit_req, start_fill, beat_wr, last_beat, fault_abort;
    logic [IDX_BITS-1:0]  rd_idx, fill_idx;
    logic [TAG_BITS-1:0]  rd_tag, fill_tag;
    logic [OFF_BITS-1:0]  word_num;
    logic [WAYS-1:0]      way_hit, way_valid;
    logic [LINE_BITS-1:0] way_line [WAYS];
    logic [LINE_BITS-1:0] sel_line;

`ifdef ICACHE_FLUSH_EN
    assign flush = bus.flush;
`else
    assign flush = 1'b0;
`endif

    assign rd_idx   = bus.paddr[OFF_BITS +: IDX_BITS];
    assign rd_tag   = bus.paddr[PA-1 -: TAG_BITS];
    assign fill_idx = tag_q[IDX_BITS-1:0];
    assign fill_tag = tag_q[LA_BITS-1:IDX_BITS];
    assign word_num = bus.paddr[OFF_BITS-1:0] >> RVB_BITS;

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a miss opens a fill; flush, fault or the last beat closes it.
    // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_fill) state_d = FILL;
            FILL:    if (flush || fault_abort || last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: lookup qualification and fill-side strobes; flush outranks everything.
    always_comb begin
        hit_int     = (state_q == IDLE) && (|way_hit);
        hit_req     = 1'b0;
        start_fill  = 1'b0;
        beat_wr     = 1'b0;
        last_beat   = 1'b0;
        fault_abort = 1'b0;
        case (state_q)
            IDLE: begin
                hit_req    = bus.req && hit_int && !flush;
                start_fill = bus.req && !hit_int && !flush;
            end
            FILL: begin
                fault_abort = bus.fault && !flush;
                beat_wr     = bus.wstrobe_d && !bus.fault && !flush;
                last_beat   = beat_wr && (beat_q == BEAT_BITS'(NBEATS - 1));
            end
            default: ;
        endcase
    end

    // Fill bookkeeping: latched line address, victim way, beat counter and the error pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q    <= '0;
            beat_q   <= '0;
            victim_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= fault_abort;
            if (start_fill) begin
                tag_q    <= bus.paddr[PA-1:OFF_BITS];
                victim_q <= victim_d;
            end
            if ((state_q == FILL) && (state_d == IDLE)) begin
                beat_q <= '0;
            end else if (beat_wr) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    if (WAYS == 2) begin : g_lru
        logic [NSETS-1:0] lru_q;

        // Victim: first invalid way (way 0 first), otherwise the LRU way of the set.
        always_comb begin
            if (!way_valid[0]) begin
                victim_d = 1'b0;
            end else if (!way_valid[1]) begin
                victim_d = 1'b1;
            end else begin
                victim_d = lru_q[rd_idx];
            end
        end

        // LRU bit per set points at the way to evict next.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                lru_q <= '0;
            end else if (flush) begin
                lru_q <= '0;
            end else if (hit_req) begin
                lru_q[rd_idx] <= ~way_hit[1];
            end else if (last_beat) begin
                lru_q[fill_idx] <= ~victim_q;
            end
        end
    end else begin : g_no_lru
        assign victim_d = 1'b0;
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic sel;
        assign sel = (victim_q == 1'(w));

        icache_way #(
            .NSETS     (NSETS),
            .IDX_BITS  (IDX_BITS),
            .TAG_BITS  (TAG_BITS),
            .LINE_BITS (LINE_BITS),
            .DW        (DW),
            .BEAT_BITS (BEAT_BITS)
        ) u_way (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush_i   (flush),
            .inval_i   (fault_abort && sel),
            .wr_en_i   (beat_wr && sel),
            .commit_i  (last_beat && sel),
            .wr_idx_i  (fill_idx),
            .wr_tag_i  (fill_tag),
            .wr_beat_i (beat_q),
            .wr_data_i (bus.dread),
            .rd_idx_i  (rd_idx),
            .rd_tag_i  (rd_tag),
            .valid_o   (way_valid[w]),
            .hit_o     (way_hit[w]),
            .line_o    (way_line[w])
        );
    end

    // Read data: the hitting way's line, narrowed to the addressed fetch word.
    always_comb begin
        sel_line  = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) sel_line = way_line[w];
        end
        bus.rdata = '0;
        if (hit_int) bus.rdata = sel_line[int'(word_num) * RV +: RV];
    end

    assign bus.hit  = hit_int;
    assign bus.pull = (state_q == FILL);
    assign bus.tag  = tag_q;
    assign bus.err  = err_q;

endmodule
